// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: load sizes and the buffered commit entry.
package wb_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [1:0] {
    LS_B = 2'd0,
    LS_H = 2'd1,
    LS_W = 2'd2,
    LS_D = 2'd3
  } load_size_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      rd;
    logic            wen;
    logic [XLEN-1:0] result;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage handshake plus register-file write / commit trace signals of the writeback stage.
interface wb_stage_if;
  import wb_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;
  logic [4:0]      in_rd;
  logic            in_wen;
  logic            in_is_load;
  logic [1:0]      in_load_size;
  logic            in_load_unsigned;
  logic [2:0]      in_addr_lo;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_mem_rdata;
  logic            wb_stall;
  logic            we;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] debug_wb_pc;
  logic [31:0]     debug_wb_inst;
  logic            commit_valid;
  logic [XLEN-1:0] instret;

  modport master (
    output in_valid, in_pc, in_inst, in_rd, in_wen, in_is_load, in_load_size,
           in_load_unsigned, in_addr_lo, in_alu_result, in_mem_rdata, wb_stall,
    input  in_ready, we, waddr, wdata, debug_wb_pc, debug_wb_inst, commit_valid, instret
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_rd, in_wen, in_is_load, in_load_size,
           in_load_unsigned, in_addr_lo, in_alu_result, in_mem_rdata, wb_stall,
    output in_ready, we, waddr, wdata, debug_wb_pc, debug_wb_inst, commit_valid, instret
  );

endinterface

// File: rtl/load_align.sv
// Selects the addressed lane of a loaded doubleword and sign/zero-extends it to XLEN.
module load_align
  import wb_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      addr_lo_i,
  input  load_size_e      size_i,
  input  logic            uns_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] lane;
  logic            sx;

  assign sx = ~uns_i;

  always_comb begin
    lane     = rdata_i;
    result_o = rdata_i;
    unique case (size_i)
      LS_B: begin
        lane     = rdata_i >> {addr_lo_i, 3'b000};
        result_o = {{56{sx & lane[7]}}, lane[7:0]};
      end
      // Sub-lane address bits below the access size are ignored.
      LS_H: begin
        lane     = rdata_i >> {addr_lo_i[2:1], 4'b0000};
        result_o = {{48{sx & lane[15]}}, lane[15:0]};
      end
      LS_W: begin
        lane     = rdata_i >> {addr_lo_i[2], 5'b00000};
        result_o = {{32{sx & lane[31]}}, lane[31:0]};
      end
      LS_D: result_o = rdata_i;
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// In-order writeback stage: 2-entry skid FIFO with empty-bypass, registered regfile write
// port and commit trace, retired-instruction counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = wb_pkg::XLEN,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic      clk,
  input logic      rst,
  wb_stage_if.slave bus
);

  wb_entry_t       mem_q [2];
  logic            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            full, empty, accept, commit, push, pop;
  logic [XLEN-1:0] ld_res;
  wb_entry_t       new_entry, head;

  logic            we_q, we_d, cv_q, cv_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d, pc_q, pc_d, instret_q, instret_d;
  logic [31:0]     inst_q, inst_d;

  assign full         = (cnt_q == 2'(FIFO_DEPTH));
  assign empty        = (cnt_q == 2'd0);
  assign bus.in_ready = ~full;
  assign accept       = bus.in_valid & ~full;

  load_align u_load_align (
    .rdata_i  (bus.in_mem_rdata),
    .addr_lo_i(bus.in_addr_lo),
    .size_i   (load_size_e'(bus.in_load_size)),
    .uns_i    (bus.in_load_unsigned),
    .result_o (ld_res)
  );

  always_comb begin
    new_entry        = '0;
    new_entry.pc     = bus.in_pc;
    new_entry.inst   = bus.in_inst;
    new_entry.rd     = bus.in_rd;
    new_entry.wen    = bus.in_wen;
    new_entry.result = bus.in_is_load ? ld_res : bus.in_alu_result;
  end

  assign head   = empty ? new_entry : mem_q[rd_ptr_q];
  assign commit = ~bus.wb_stall & (~empty | accept);
  // A bypassed instruction commits straight from the input and never enters the FIFO.
  assign push   = accept & ~(empty & commit);
  assign pop    = commit & ~empty;

  always_comb begin
    cnt_d     = cnt_q + 2'(push) - 2'(pop);
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    we_d      = commit & head.wen & (head.rd != 5'd0);
    cv_d      = commit;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    if (commit) begin
      waddr_d   = head.rd;
      wdata_d   = head.result;
      pc_d      = head.pc;
      inst_d    = head.inst;
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      we_q      <= 1'b0;
      cv_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pc_q      <= '0;
      inst_q    <= '0;
      instret_q <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= new_entry;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      cv_q      <= cv_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
    end
  end

  assign bus.we            = we_q;
  assign bus.commit_valid  = cv_q;
  assign bus.waddr         = waddr_q;
  assign bus.wdata         = wdata_q;
  assign bus.debug_wb_pc   = pc_q;
  assign bus.debug_wb_inst = inst_q;
  assign bus.instret       = instret_q;

endmodule
